// File: rtl/mul_seq.sv
// mul_seq: multi-cycle unsigned shift-add multiplier sequencer.
//
// It drives the shared combinational ALU with one ADD per cycle and builds a
// 2*SIZE-bit product from the ALU sum and carry-out. The low word (MUL) or the
// high word (MULHU, f3_i == 3'b011) is returned on result_o.
//
// Optional feature macro: MUL_EARLY_EXIT_EN. When it is defined, the block
// finishes as soon as the remaining multiplier bits are all zero. When it is
// undefined, every operation takes SIZE iterations.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start_i    request, accepted when ready_o = 1
//   f3_i       3'b011 selects MULHU, any other value selects MUL
//   op1_i      multiplicand, captured on accept
//   op2_i      multiplier, captured on accept
//   ready_o    high in IDLE and DONE
//   busy_o     high while iterating
//   done_o     one-cycle pulse; result_o is valid
//   result_o   selected product word, held until the next result
//   alu_f3_o   ALU funct3, always ADD/SUB group
//   alu_f7_o   ALU funct7, always ADD
//   alu_op1_o  accumulator while busy, else 0
//   alu_op2_o  multiplicand if the current multiplier bit is set, else 0
//   alu_res_i  ALU sum, same cycle
//   alu_c_i    ALU carry-out
module mul_seq #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      f3_i,
    input  logic [SIZE-1:0] op1_i,
    input  logic [SIZE-1:0] op2_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [SIZE-1:0] result_o,
    output logic [2:0]      alu_f3_o,
    output logic [6:0]      alu_f7_o,
    output logic [SIZE-1:0] alu_op1_o,
    output logic [SIZE-1:0] alu_op2_o,
    input  logic [SIZE-1:0] alu_res_i,
    input  logic            alu_c_i
);

    localparam int unsigned CntW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   mcand_q, mcand_d;
    logic [SIZE-1:0]   mplier_q, mplier_d;
    logic [SIZE-1:0]   acc_q, acc_d;
    logic [SIZE-1:0]   lo_q, lo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              hisel_q, hisel_d;
    logic [SIZE-1:0]   result_q, result_d;

    // Sum and carry shifted in at the top, product shifted right by one.
    logic [2*SIZE-1:0] prod_next;
    logic [2*SIZE-1:0] prod_fin;
    logic              last_iter;

    assign prod_next = {alu_c_i, alu_res_i, lo_q[SIZE-1:1]};

`ifdef MUL_EARLY_EXIT_EN
    logic [CntW-1:0] shamt;
    // Remaining iterations would only add zero and shift, so do them in one go.
    assign shamt     = CntW'(SIZE - 1) - cnt_q;
    assign prod_fin  = prod_next >> shamt;
    assign last_iter = (cnt_q == CntW'(SIZE - 1)) || ((mplier_q >> 1) == '0);
`else
    assign prod_fin  = prod_next;
    assign last_iter = (cnt_q == CntW'(SIZE - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            hisel_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            hisel_q  <= hisel_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        hisel_d  = hisel_q;
        result_d = result_q;

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    mcand_d  = op1_i;
                    mplier_d = op2_i;
                    acc_d    = '0;
                    lo_d     = '0;
                    cnt_d    = '0;
                    hisel_d  = (f3_i == 3'b011);
                    state_d  = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                acc_d    = prod_next[2*SIZE-1:SIZE];
                lo_d     = prod_next[SIZE-1:0];
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = hisel_q ? prod_fin[2*SIZE-1:SIZE] : prod_fin[SIZE-1:0];
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o    = (state_q == StBusy);
    assign ready_o   = ~busy_o;
    assign done_o    = (state_q == StDone);
    assign result_o  = result_q;
    assign alu_f3_o  = 3'b000;
    assign alu_f7_o  = 7'b0000000;
    assign alu_op1_o = busy_o ? acc_q : '0;
    assign alu_op2_o = (busy_o && mplier_q[0]) ? mcand_q : '0;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a behavioural ALU closes the loop, and
// expected words and latencies come from plain 64-bit arithmetic.
module tb_mul_seq;

    localparam int unsigned SIZE = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      f3_i;
    logic [SIZE-1:0] op1_i, op2_i;
    logic            ready_o, busy_o, done_o;
    logic [SIZE-1:0] result_o;
    logic [2:0]      alu_f3_o;
    logic [6:0]      alu_f7_o;
    logic [SIZE-1:0] alu_op1_o, alu_op2_o;
    logic [SIZE-1:0] alu_res;
    logic            alu_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign {alu_c, alu_res} = {1'b0, alu_op1_o} + {1'b0, alu_op2_o};

    mul_seq #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .f3_i      (f3_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .alu_f3_o  (alu_f3_o),
        .alu_f7_o  (alu_f7_o),
        .alu_op1_o (alu_op1_o),
        .alu_op2_o (alu_op2_o),
        .alu_res_i (alu_res),
        .alu_c_i   (alu_c)
    );

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return (f3 == 3'b011) ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int hb;
        hb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        return (b == 0) ? 1 : hb + 1;
`else
        return (b == b) ? 32 : 32;
`endif
    endfunction

    // Present a request; returns 1 ns after the accept edge with start_i low.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        @(negedge clk);
        start_i = 1'b1;
        op1_i   = a;
        op2_i   = b;
        f3_i    = f3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Counts edges until done_o; gathers busy cycles and ready/busy disagreement.
    task automatic wait_done(output int lat, output int busy_cnt, output int rdy_err,
                             output logic timed_out);
        lat = 0;
        busy_cnt = 0;
        rdy_err = 0;
        while (!done_o && lat < 200) begin
            if (busy_o) busy_cnt++;
            if (ready_o === busy_o) rdy_err++;
            @(posedge clk);
            #1;
            lat++;
        end
        timed_out = !done_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        f3_i = 3'b000;
        op1_i = '0;
        op2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({ready_o, busy_o, done_o} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags: got rdy/busy/done=%b want 100", {ready_o, busy_o, done_o});
        end
        total++;
        if (result_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_result: got %h want 00000000", result_o);
        end
        total++;
        if ({alu_op1_o, alu_op2_o, alu_f3_o, alu_f7_o} !== '0) begin
            bad++;
            $display("FAIL reset_alu: got op1=%h op2=%h f3=%b f7=%b want all zero",
                     alu_op1_o, alu_op2_o, alu_f3_o, alu_f7_o);
        end
    endtask

    task automatic test_directed();
        logic [31:0] a [5] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd1234};
        logic [31:0] b [5] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0};
        logic [2:0]  f [5] = '{3'b000, 3'b011, 3'b000, 3'b000, 3'b000};
        int lat, bc, re;
        logic to;
        for (int i = 0; i < 5; i++) begin
            launch(a[i], b[i], f[i]);
            wait_done(lat, bc, re, to);
            total++;
            if (to || lat != ref_lat(b[i])) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got %0d edges want %0d", i, lat, ref_lat(b[i]));
            end
            total++;
            if (result_o !== ref_word(a[i], b[i], f[i])) begin
                bad++;
                $display("FAIL dir_result[%0d]: got %h want %h", i, result_o,
                         ref_word(a[i], b[i], f[i]));
            end
            total++;
            if (bc != ref_lat(b[i]) || re != 0) begin
                bad++;
                $display("FAIL dir_busy[%0d]: got busy=%0d rdyerr=%0d want busy=%0d rdyerr=0",
                         i, bc, re, ref_lat(b[i]));
            end
            @(posedge clk);
            #1;
            total++;
            if (done_o !== 1'b0 || ready_o !== 1'b1 || result_o !== ref_word(a[i], b[i], f[i])) begin
                bad++;
                $display("FAIL dir_hold[%0d]: got done=%b rdy=%b res=%h want 0 1 %h", i, done_o,
                         ready_o, result_o, ref_word(a[i], b[i], f[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [2:0] f;
        int lat, bc, re;
        logic to;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = b >> $urandom_range(31, 0);
            f = ($urandom_range(1, 0) != 0) ? 3'b011 : 3'($urandom_range(7, 0));
            launch(a, b, f);
            wait_done(lat, bc, re, to);
            total++;
            if (to || lat != ref_lat(b) || result_o !== ref_word(a, b, f) || re != 0) begin
                bad++;
                $display("FAIL rnd[%0d] a=%h b=%h f3=%b: got res=%h lat=%0d rdyerr=%0d want res=%h lat=%0d",
                         i, a, b, f, result_o, lat, re, ref_word(a, b, f), ref_lat(b));
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, re, pulses;
        logic to;
        launch(32'hDEAD_BEEF, 32'h8000_0001, 3'b000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({ready_o, busy_o, done_o} !== 3'b100 || result_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: got rdy/busy/done=%b res=%h want 100 00000000",
                     {ready_o, busy_o, done_o}, result_o);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: got %0d active cycles want 0", pulses);
        end
        launch(32'd100, 32'd250, 3'b000);
        wait_done(lat, bc, re, to);
        total++;
        if (to || result_o !== 32'd25000 || lat != ref_lat(32'd250)) begin
            bad++;
            $display("FAIL rst_mid_restart: got res=%h lat=%0d want %h %0d", result_o, lat,
                     32'd25000, ref_lat(32'd250));
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, re;
        logic to;
        logic [31:0] a, b;
        launch(32'd7, 32'd6, 3'b000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        op1_i = 32'd9;
        op2_i = 32'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done(lat, bc, re, to);
        total++;
        if (to || result_o !== 32'd42 || lat + 6 != ref_lat(32'd6)) begin
            bad++;
            $display("FAIL busy_start_ignored: got res=%h lat=%0d want 0000002a %0d", result_o,
                     lat + 6, ref_lat(32'd6));
        end
        a = $urandom;
        b = $urandom;
        launch(a, b, 3'b011);
        total++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy_o, done_o);
        end
        wait_done(lat, bc, re, to);
        total++;
        if (to || result_o !== ref_word(a, b, 3'b011) || lat != ref_lat(b)) begin
            bad++;
            $display("FAIL b2b_result: got res=%h lat=%0d want %h %0d", result_o, lat,
                     ref_word(a, b, 3'b011), ref_lat(b));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle unsigned shift-add multiplier sequencer for the execute stage. It drives the shared combinational ALU with ADD operations, one per cycle, and accumulates a 2·SIZE-bit product from the sum and carry-out. It returns either the low word (MUL) or the high word (MULHU). The execute stage holds the instruction while `busy_o` is high.

## Interface
- `SIZE`, 32, operand/ALU width; the iteration counter is clog2(SIZE)+1 bits.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; accepted on an edge where `ready_o`=1.
- `f3_i`  in  3  3'b011 = MULHU (high word); any other value = MUL (low word).
- `op1_i`  in  SIZE  multiplicand, captured on accept.
- `op2_i`  in  SIZE  multiplier, captured on accept.
- `ready_o`  out  1  high in IDLE and DONE.
- `busy_o`  out  1  high in BUSY.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid.
- `result_o`  out  SIZE  selected product word, held until the next accept.
- `alu_f3_o`  out  3  always 3'b000 (ADD/SUB group).
- `alu_f7_o`  out  7  always 7'b0000000 (ADD).
- `alu_op1_o`  out  SIZE  accumulator `acc` during BUSY, else 0.
- `alu_op2_o`  out  SIZE  `mcand` if `mplier[0]`=1, else 0; 0 outside BUSY.
- `alu_res_i`  in  SIZE  ALU sum, same cycle (combinational path).
- `alu_c_i`  in  1  carry-out of the SIZE-bit add.

## Operation
- Registers:
  - `mcand`, `mplier`, `acc` (SIZE bits each).
  - `lo` (SIZE bits, product low part).
  - `cnt` (iteration count).
  - `hisel` (1 = MULHU).
  - `state`: IDLE, BUSY or DONE.
- Reset:
  - State goes to IDLE; all registers are 0.
  - `result_o`=0, `done_o`=0, `busy_o`=0, `ready_o`=1.
- Accept (IDLE or DONE, `start_i`=1):
  - `mcand`←op1_i, `mplier`←op2_i, `acc`←0, `lo`←0, `cnt`←0, `hisel`←(f3_i==3'b011).
  - State goes to BUSY.
- BUSY, each edge performs one iteration:
  - {c,s} = {alu_c_i, alu_res_i}.
  - {acc, lo} ← {c, s, lo[SIZE-1:1]}; this is the 2·SIZE+1-bit value shifted right by 1, and s[0] enters `lo[SIZE-1]`.
  - `mplier` ← `mplier`>>1; `cnt`←`cnt`+1.
  - When `cnt`+1 == SIZE, the state goes to DONE and the product is {acc, lo}.
- Entering DONE: `result_o` ← `hisel` ? product[2·SIZE-1:SIZE] : product[SIZE-1:0]; `done_o`=1 for that single cycle.
- DONE with no `start_i`: the state goes to IDLE on the next edge and `result_o` is held.
- Back-to-back: `start_i` in DONE is accepted, so DONE leads directly to BUSY.
- `start_i` during BUSY is ignored; no queueing and no error.
- Operands are unsigned. Zero operands still take the full iteration count unless early exit is compiled in.
- The ALU has no other master while `busy_o`=1. The execute stage muxes the ALU inputs on `busy_o`.

## Timing
- Accept edge is E0.
- `busy_o`=1 in the cycles after E0 through E(SIZE-1).
- Edge E(SIZE) commits the last iteration; `done_o`=1 and `result_o` is valid in the cycle after E(SIZE).
- Latency is SIZE edges from accept to done (32 by default).
- `ready_o`=0 exactly while `busy_o`=1.
- ALU outputs change only on `clk` edges; the ALU path is a single-cycle combinational loop.
- `rst` asserted mid-BUSY: on that edge the block goes to IDLE, the result is discarded, `result_o`=0, and no `done_o` pulse occurs.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - On a BUSY edge where `mplier`>>1 == 0 after the iteration, the block goes to DONE immediately.
  - Product = {acc_next, lo_next} >> (SIZE-1-cnt), a logical shift covering the remaining iterations.
  - Latency = max(1, index of the highest set bit of op2 + 1) edges; op2=0 gives 1 edge.
- Undefined: fixed SIZE-edge latency for every operand. The shifter logic is not present.

## Test plan
- op1=7, op2=6, f3=000: `done_o` one cycle after E32, `result_o`=0x0000002A; `busy_o` high for 32 cycles.
- op1=op2=0xFFFFFFFF, f3=011: `result_o`=0xFFFFFFFE. Rerun with f3=000: `result_o`=0x00000001 (exercises the carry path).
- Assert `rst` at E10 of an active multiply: next cycle IDLE, `busy_o`=0, `result_o`=0, no `done_o`. A new start then completes normally.
- Pulse `start_i` with op1=9, op2=9 during BUSY of 7×6: it is ignored and `result_o`=42. A start in the DONE cycle is accepted, with `busy_o`=1 next cycle.
- With `MUL_EARLY_EXIT_EN`: op1=3, op2=5 gives `done_o` after E3 and `result_o`=15; op2=0 gives `done_o` after E1 and `result_o`=0. Without the macro, both cases complete after E32 with the same values.
